pipe_trace_buffer: RTL and testbench

Synthesizable, parametrised pipeline trace capture unit for the MIPS core. It samples NUM_CH probe words per cycle, such as IF PC, IF/ID instruction, EX ALU result and WB write-back data, into a circular buffer. Capture is gated by pipeline sample-enable and starts on a PC-match or forced trigger. After the trigger it records POST_DEPTH further samples, then freezes so the debug path can read the buffer back. This moves the per-stage monitoring done in simulation into hardware, adding trigger, pre/post windows and readback.

---
 rtl/pipe_trace_pkg.sv | 14 +
 rtl/trace_ram.sv | 29 ++
 rtl/pipe_trace_buffer.sv | 142 ++++++++++++++
 tb/tb_pipe_trace_buffer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_trace_pkg.sv
// Shared types for the pipeline trace buffer.
// Provides the capture FSM state encoding and its width.
package pipe_trace_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/trace_ram.sv
// Sample store: one synchronous write port, one registered read port.
// Ports: clk/rst_n, we/waddr/wdata write, re/raddr read, rdata registered row.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Trace capture: armed circular buffer, PC-match/forced trigger, post window.
// Ports: probe/trigger/control inputs, 2-stage read port, State/Fill/Trig_Index.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 16,
  parameter int POST_DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int FW = AW + 1
) (
  input  logic                     clk_in,
  input  logic                     Reset,
  input  logic [NUM_CH*DATA_W-1:0] Probe_In,
  input  logic                     Probe_Valid,
  input  logic                     Arm,
  input  logic                     Abort,
  input  logic                     Trig_En,
  input  logic [DATA_W-1:0]        Trig_Value,
  input  logic                     Force_Trig,
  input  logic                     Rd_En,
  input  logic [AW-1:0]            Rd_Addr,
  input  logic [CW-1:0]            Rd_Ch,
  output logic [DATA_W-1:0]        Rd_Data,
  output logic                     Rd_Valid,
  output logic [STATE_W-1:0]       State,
  output logic [FW-1:0]            Fill_Count,
  output logic [AW-1:0]            Trig_Index
);

  state_e                   state;
  logic [AW-1:0]            wr_ptr;
  logic [FW-1:0]            fill;
  logic [FW-1:0]            post_cnt;
  logic [FW-1:0]            fill_inc;
  logic                     trig;
  logic                     store;
  logic                     rd_fire;
  logic [AW-1:0]            rd_phys;
  logic [NUM_CH*DATA_W-1:0] row;
  logic                     rd_req_q;
  logic                     rd_oor_q;
  logic [CW-1:0]            rd_ch_q;

  assign trig = Probe_Valid && (Force_Trig ||
    (Trig_En && Probe_In[DATA_W-1:0] == Trig_Value));
  assign store = Probe_Valid && !Abort &&
    (state == ARMED || state == POST);
  assign fill_inc = (fill == FW'(DEPTH)) ? fill : fill + 1'b1;
  // Oldest sample sits fill slots behind the write pointer.
  assign rd_phys = wr_ptr - fill[AW-1:0] + Rd_Addr;
  assign rd_fire = Rd_En && (state == DONE);

  assign State      = state;
  assign Fill_Count = fill;

  always_ff @(posedge clk_in or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      fill       <= '0;
      post_cnt   <= '0;
      Trig_Index <= '0;
    end else if (Abort) begin
      state <= IDLE;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
        fill   <= fill_inc;
      end
      unique case (state)
        IDLE, DONE: begin
          if (Arm) begin
            state    <= ARMED;
            wr_ptr   <= '0;
            fill     <= '0;
            post_cnt <= '0;
          end
        end
        ARMED: begin
          if (trig) begin
            post_cnt <= '0;
            if (POST_DEPTH == 0) begin
              state      <= DONE;
              Trig_Index <= AW'(fill_inc - 1'b1);
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (Probe_Valid) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt + 1'b1 == FW'(POST_DEPTH)) begin
              state      <= DONE;
              Trig_Index <= AW'(fill_inc - FW'(POST_DEPTH + 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (NUM_CH * DATA_W)
  ) u_ram (
    .clk   (clk_in),
    .rst_n (Reset),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (Probe_In),
    .re    (rd_fire),
    .raddr (rd_phys),
    .rdata (row)
  );

  // Stage 1 latches the request alongside the RAM row;
  // stage 2 picks the channel and drives the outputs.
  always_ff @(posedge clk_in or negedge Reset) begin
    if (!Reset) begin
      rd_req_q <= 1'b0;
      rd_oor_q <= 1'b0;
      rd_ch_q  <= '0;
      Rd_Valid <= 1'b0;
      Rd_Data  <= '0;
    end else begin
      rd_req_q <= rd_fire;
      rd_oor_q <= {1'b0, Rd_Addr} >= fill;
      rd_ch_q  <= Rd_Ch;
      Rd_Valid <= rd_req_q;
      if (rd_req_q) begin
        Rd_Data <= rd_oor_q ? '0 :
          row[int'(rd_ch_q)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer (default and DEPTH=8/POST=0).
// Each task drives one scenario and checks against hand-computed values.
module tb_pipe_trace_buffer;

  logic         clk_in = 1'b0;
  logic         Reset = 1'b0;
  logic [127:0] Probe_In = '0;
  logic         Probe_Valid = 1'b0;
  logic         Arm = 1'b0;
  logic         Abort = 1'b0;
  logic         Trig_En = 1'b0;
  logic [31:0]  Trig_Value = '0;
  logic         Force_Trig = 1'b0;
  logic         Rd_En = 1'b0;
  logic [3:0]   rd_addr = '0;
  logic [1:0]   Rd_Ch = '0;

  logic [31:0]  Rd_Data;
  logic         Rd_Valid;
  logic [1:0]   State;
  logic [4:0]   Fill_Count;
  logic [3:0]   Trig_Index;

  logic [31:0]  rd_data8;
  logic         rd_valid8;
  logic [1:0]   state8;
  logic [3:0]   fill8;
  logic [2:0]   trig_idx8;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  pipe_trace_buffer u_dut (
    .clk_in      (clk_in),
    .Reset       (Reset),
    .Probe_In    (Probe_In),
    .Probe_Valid (Probe_Valid),
    .Arm         (Arm),
    .Abort       (Abort),
    .Trig_En     (Trig_En),
    .Trig_Value  (Trig_Value),
    .Force_Trig  (Force_Trig),
    .Rd_En       (Rd_En),
    .Rd_Addr     (rd_addr),
    .Rd_Ch       (Rd_Ch),
    .Rd_Data     (Rd_Data),
    .Rd_Valid    (Rd_Valid),
    .State       (State),
    .Fill_Count  (Fill_Count),
    .Trig_Index  (Trig_Index)
  );

  pipe_trace_buffer #(
    .DEPTH      (8),
    .POST_DEPTH (0)
  ) u_dut8 (
    .clk_in      (clk_in),
    .Reset       (Reset),
    .Probe_In    (Probe_In),
    .Probe_Valid (Probe_Valid),
    .Arm         (Arm),
    .Abort       (Abort),
    .Trig_En     (Trig_En),
    .Trig_Value  (Trig_Value),
    .Force_Trig  (Force_Trig),
    .Rd_En       (Rd_En),
    .Rd_Addr     (rd_addr[2:0]),
    .Rd_Ch       (Rd_Ch),
    .Rd_Data     (rd_data8),
    .Rd_Valid    (rd_valid8),
    .State       (state8),
    .Fill_Count  (fill8),
    .Trig_Index  (trig_idx8)
  );

  function automatic logic [31:0] chv(input logic [31:0] pc,
                                      input int k);
    case (k)
      0: chv = pc;
      1: chv = pc ^ 32'hAAAA0000;
      2: chv = pc + 32'd1;
      default: chv = ~pc;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic v,
                      input logic ft);
    Probe_In    = {chv(pc, 3), chv(pc, 2), chv(pc, 1), chv(pc, 0)};
    Probe_Valid = v;
    Force_Trig  = ft;
    tick();
    Probe_Valid = 1'b0;
    Force_Trig  = 1'b0;
    Arm         = 1'b0;
    Abort       = 1'b0;
  endtask

  task automatic arm();
    Arm = 1'b1;
    tick();
    Arm = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [1:0] ch,
                         output logic [31:0] d, output logic v);
    Rd_En   = 1'b1;
    rd_addr = a;
    Rd_Ch   = ch;
    tick();
    Rd_En = 1'b0;
    tick();
    d = Rd_Data;
    v = Rd_Valid;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (State !== 2'd0 || Fill_Count !== 5'd0 || Trig_Index !== 4'd0 ||
        Rd_Data !== 32'd0 || Rd_Valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: st=%0d fc=%0d ti=%0d rd=%h rv=%b exp 0s",
               State, Fill_Count, Trig_Index, Rd_Data, Rd_Valid);
    end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_pc_match();
    arm();
    Trig_En    = 1'b1;
    Trig_Value = 32'h40;
    for (int i = 0; i <= 24; i++) begin
      push(32'(i * 4), 1'b1, 1'b0);
      if (i == 23) begin
        checks++;
        if (State !== 2'd2) begin
          errors++;
          $display("FAIL pcm_post: state=%0d exp 2", State);
        end
      end
    end
    Trig_En = 1'b0;
    checks++;
    if (State !== 2'd3 || Fill_Count !== 5'd16 ||
        Trig_Index !== 4'd7) begin
      errors++;
      $display("FAIL pcm_done: st=%0d fc=%0d ti=%0d exp 3/16/7",
               State, Fill_Count, Trig_Index);
    end
    // back-to-back reads: addr 0 ch0, addr 7 ch0, addr 15 ch2
    Rd_En = 1'b1; rd_addr = 4'd0; Rd_Ch = 2'd0;
    tick();
    rd_addr = 4'd7;
    tick();
    checks++;
    if (Rd_Data !== 32'h24 || Rd_Valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_a0: got %h/%b exp 24/1", Rd_Data, Rd_Valid);
    end
    rd_addr = 4'd15; Rd_Ch = 2'd2;
    tick();
    checks++;
    if (Rd_Data !== 32'h40 || Rd_Valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_a7: got %h/%b exp 40/1", Rd_Data, Rd_Valid);
    end
    Rd_En = 1'b0;
    tick();
    checks++;
    if (Rd_Data !== 32'h61 || Rd_Valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_a15: got %h/%b exp 61/1", Rd_Data, Rd_Valid);
    end
    tick();
    checks++;
    if (Rd_Valid !== 1'b0) begin
      errors++;
      $display("FAIL rv_pulse: got %b exp 0", Rd_Valid);
    end
  endtask

  task automatic test_early_trigger();
    logic [31:0] d;
    logic        v;
    arm();
    for (int i = 0; i < 11; i++)
      push(32'h200 + 32'(i * 4), 1'b1, i == 2);
    checks++;
    if (State !== 2'd3 || Fill_Count !== 5'd11 ||
        Trig_Index !== 4'd2) begin
      errors++;
      $display("FAIL early_done: st=%0d fc=%0d ti=%0d exp 3/11/2",
               State, Fill_Count, Trig_Index);
    end
    do_read(4'd2, 2'd3, d, v);
    checks++;
    if (d !== ~32'h208 || v !== 1'b1) begin
      errors++;
      $display("FAIL early_rd2: got %h/%b exp %h/1", d, v, ~32'h208);
    end
    do_read(4'd12, 2'd0, d, v);
    checks++;
    if (d !== 32'd0 || v !== 1'b1) begin
      errors++;
      $display("FAIL early_oor: got %h/%b exp 0/1", d, v);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    logic        v;
    arm();
    for (int i = 0; i < 6; i++)
      push(32'h100 + 32'(i * 4), 1'b1, i == 2);
    for (int s = 0; s < 5; s++) begin
      push(32'hDEAD0000, 1'b0, 1'b0);
      checks++;
      if (State !== 2'd2 || Fill_Count !== 5'd6) begin
        errors++;
        $display("FAIL stall_hold%0d: st=%0d fc=%0d exp 2/6",
                 s, State, Fill_Count);
      end
    end
    for (int i = 6; i < 11; i++) begin
      push(32'h100 + 32'(i * 4), 1'b1, 1'b0);
      if (i == 9) begin
        checks++;
        if (State !== 2'd2) begin
          errors++;
          $display("FAIL stall_early: state=%0d exp 2", State);
        end
      end
    end
    checks++;
    if (State !== 2'd3 || Fill_Count !== 5'd11 ||
        Trig_Index !== 4'd2) begin
      errors++;
      $display("FAIL stall_done: st=%0d fc=%0d ti=%0d exp 3/11/2",
               State, Fill_Count, Trig_Index);
    end
    do_read(4'd6, 2'd0, d, v);
    checks++;
    if (d !== 32'h118 || v !== 1'b1) begin
      errors++;
      $display("FAIL stall_rd6: got %h/%b exp 118/1", d, v);
    end
    do_read(4'd4, 2'd1, d, v);
    checks++;
    if (d !== (32'h110 ^ 32'hAAAA0000) || v !== 1'b1) begin
      errors++;
      $display("FAIL stall_rd4c1: got %h/%b exp aaaa0110/1", d, v);
    end
    do_read(4'd10, 2'd0, d, v);
    checks++;
    if (d !== 32'h128 || v !== 1'b1) begin
      errors++;
      $display("FAIL stall_rd10: got %h/%b exp 128/1", d, v);
    end
  endtask

  task automatic test_control();
    logic [31:0] d;
    logic        v;
    arm();
    push(32'h400, 1'b1, 1'b0);
    push(32'h404, 1'b1, 1'b0);
    Arm = 1'b1;
    push(32'h408, 1'b1, 1'b0);
    checks++;
    if (State !== 2'd1 || Fill_Count !== 5'd3) begin
      errors++;
      $display("FAIL arm_ignored: st=%0d fc=%0d exp 1/3",
               State, Fill_Count);
    end
    push(32'h40C, 1'b1, 1'b1);
    push(32'h410, 1'b1, 1'b0);
    Abort = 1'b1;
    push(32'h414, 1'b1, 1'b0);
    checks++;
    if (State !== 2'd0 || Fill_Count !== 5'd5) begin
      errors++;
      $display("FAIL abort_post: st=%0d fc=%0d exp 0/5",
               State, Fill_Count);
    end
    do_read(4'd0, 2'd0, d, v);
    checks++;
    if (v !== 1'b0 || d !== 32'h128) begin
      errors++;
      $display("FAIL idle_read: got %h/%b exp 128/0", d, v);
    end
    arm();
    for (int i = 0; i < 9; i++)
      push(32'h500 + 32'(i * 4), 1'b1, i == 0);
    checks++;
    if (State !== 2'd3) begin
      errors++;
      $display("FAIL ctl_done: state=%0d exp 3", State);
    end
    arm();
    checks++;
    if (State !== 2'd1 || Fill_Count !== 5'd0) begin
      errors++;
      $display("FAIL rearm_done: st=%0d fc=%0d exp 1/0",
               State, Fill_Count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++)
      push(32'h600 + 32'(i * 4), 1'b1, i == 2);
    checks++;
    if (State !== 2'd2) begin
      errors++;
      $display("FAIL ar_pre: state=%0d exp 2", State);
    end
    #3;
    Reset = 1'b0;
    #1;
    checks++;
    if (State !== 2'd0 || Fill_Count !== 5'd0 || Trig_Index !== 4'd0 ||
        Rd_Data !== 32'd0 || Rd_Valid !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: st=%0d fc=%0d ti=%0d rd=%h rv=%b exp 0s",
               State, Fill_Count, Trig_Index, Rd_Data, Rd_Valid);
    end
    #1;
    Reset = 1'b1;
    tick();
    checks++;
    if (State !== 2'd0 || Fill_Count !== 5'd0) begin
      errors++;
      $display("FAIL ar_after: st=%0d fc=%0d exp 0/0",
               State, Fill_Count);
    end
  endtask

  task automatic test_post0();
    logic [31:0] d8;
    arm();
    for (int i = 0; i < 10; i++) begin
      push(32'h300 + 32'(i * 4), 1'b1, i == 9);
      if (i == 8) begin
        checks++;
        if (state8 !== 2'd1 || fill8 !== 4'd8) begin
          errors++;
          $display("FAIL p0_armed: st=%0d fc=%0d exp 1/8",
                   state8, fill8);
        end
      end
    end
    checks++;
    if (state8 !== 2'd3 || fill8 !== 4'd8 || trig_idx8 !== 3'd7) begin
      errors++;
      $display("FAIL p0_done: st=%0d fc=%0d ti=%0d exp 3/8/7",
               state8, fill8, trig_idx8);
    end
    Rd_En = 1'b1; rd_addr = 4'd7; Rd_Ch = 2'd0;
    tick();
    rd_addr = 4'd0;
    tick();
    d8 = rd_data8;
    checks++;
    if (d8 !== 32'h324 || rd_valid8 !== 1'b1) begin
      errors++;
      $display("FAIL p0_rd7: got %h/%b exp 324/1", d8, rd_valid8);
    end
    Rd_En = 1'b0;
    tick();
    checks++;
    if (rd_data8 !== 32'h308 || rd_valid8 !== 1'b1) begin
      errors++;
      $display("FAIL p0_rd0: got %h/%b exp 308/1", rd_data8, rd_valid8);
    end
  endtask

  initial begin
    test_reset();
    test_pc_match();
    test_early_trigger();
    test_stall();
    test_control();
    test_async_reset();
    test_post0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
